// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, blanking, hs/vs sync and frame/line strobes.
// Optional VGA_TIMING_SYNC_DELAY_EN adds one register stage on hs/vs to line up with registered RGB.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       sync,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Window bounds are 11 bits so an end-of-window value of 1024 does not wrap to 0.
  localparam logic [10:0] H_VIS_END   = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END   = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG  = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_blank;
  logic       r_hs;
  logic       r_vs;
  logic       r_frame_start;
  logic       r_line_start;

  logic        w_x_wrap;
  logic        w_y_wrap;
  logic [9:0]  w_x_next;
  logic [9:0]  w_y_next;
  logic [10:0] w_x_next_ext;
  logic [10:0] w_y_next_ext;
  logic        w_blank_next;
  logic        w_hs_next;
  logic        w_vs_next;
  logic        w_line_start_next;
  logic        w_frame_start_next;

  // Next-position arithmetic; wrap is a plain equality so no overflow state exists.
  always_comb begin
    w_x_wrap = (r_x == H_LAST);
    w_y_wrap = (r_y == V_LAST);
    w_x_next = w_x_wrap ? 10'd0 : r_x + 10'd1;
    w_y_next = r_y;
    if (w_x_wrap) begin
      w_y_next = w_y_wrap ? 10'd0 : r_y + 10'd1;
    end
  end

  // Flags are decoded from the next position so, once registered, they align with DrawX/DrawY.
  always_comb begin
    w_x_next_ext       = {1'b0, w_x_next};
    w_y_next_ext       = {1'b0, w_y_next};
    w_blank_next       = (w_x_next_ext < H_VIS_END) && (w_y_next_ext < V_VIS_END);
    w_hs_next          = !((w_x_next_ext >= H_SYNC_BEG) && (w_x_next_ext < H_SYNC_END));
    w_vs_next          = !((w_y_next_ext >= V_SYNC_BEG) && (w_y_next_ext < V_SYNC_END));
    w_line_start_next  = (w_x_next == 10'd0);
    w_frame_start_next = w_line_start_next && (w_y_next == 10'd0);
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
    end else begin
      r_x           <= w_x_next;
      r_y           <= w_y_next;
      r_blank       <= w_blank_next;
      r_hs          <= w_hs_next;
      r_vs          <= w_vs_next;
      r_frame_start <= w_frame_start_next;
      r_line_start  <= w_line_start_next;
    end
  end

`ifdef VGA_TIMING_SYNC_DELAY_EN
  logic r_hs_d;
  logic r_vs_d;

  // Sync lags the coordinates by one cycle to match renderers that register RGB.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_hs_d <= 1'b1;
      r_vs_d <= 1'b1;
    end else begin
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
    end
  end

  assign hs = r_hs_d;
  assign vs = r_vs_d;
`else
  assign hs = r_hs;
  assign vs = r_vs;
`endif

  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign blank       = r_blank;
  assign sync        = 1'b0;
  assign frame_start = r_frame_start;
  assign line_start  = r_line_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance and a small-timing instance
// (H 8/2/2/2, V 4/1/1/1) share clock and reset; a reference position model is checked every cycle.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic [9:0] b_x, b_y, s_x, s_y;
  logic b_blank, b_hs, b_vs, b_sync, b_fs, b_ls;
  logic s_blank, s_hs, s_vs, s_sync, s_fs, s_ls;

  vga_timing_gen u_big (
    .vga_clk(clk), .reset(rst), .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
    .hs(b_hs), .vs(b_vs), .sync(b_sync), .frame_start(b_fs), .line_start(b_ls)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_small (
    .vga_clk(clk), .reset(rst), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
    .hs(s_hs), .vs(s_vs), .sync(s_sync), .frame_start(s_fs), .line_start(s_ls)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: position, in-reset flag, undelayed and delayed sync.
  int   bx = 0, by = 0, sx = 0, sy = 0;
  bit   b_in_rst = 1'b1, s_in_rst = 1'b1;
  logic bh = 1'b1, bv = 1'b1, bhd = 1'b1, bvd = 1'b1;
  logic sh = 1'b1, sv = 1'b1, shd = 1'b1, svd = 1'b1;
  logic [4:0] bf = 5'b0, sf = 5'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // {blank, hs_n, vs_n, frame_start, line_start} for a position, straight from the window formulas.
  function automatic logic [4:0] exp_flags(int x, int y, int hv, int hf, int hsw,
                                           int vv, int vf, int vsw);
    logic [4:0] f;
    f[4] = (x < hv) && (y < vv);
    f[3] = !((x >= hv + hf) && (x < hv + hf + hsw));
    f[2] = !((y >= vv + vf) && (y < vv + vf + vsw));
    f[1] = (x == 0) && (y == 0);
    f[0] = (x == 0);
    return f;
  endfunction

  task automatic tick();
    logic old_bh, old_bv, old_sh, old_sv;
    @(posedge clk);
    old_bh = bh; old_bv = bv; old_sh = sh; old_sv = sv;
    if (rst) begin
      bx = 0; by = 0; sx = 0; sy = 0;
      b_in_rst = 1'b1; s_in_rst = 1'b1;
      bh = 1'b1; bv = 1'b1; sh = 1'b1; sv = 1'b1;
      bhd = 1'b1; bvd = 1'b1; shd = 1'b1; svd = 1'b1;
    end else begin
      b_in_rst = 1'b0; s_in_rst = 1'b0;
      if (bx == 799) begin bx = 0; by = (by == 524) ? 0 : by + 1; end else bx++;
      if (sx == 13)  begin sx = 0; sy = (sy == 6) ? 0 : sy + 1; end else sx++;
      bf = exp_flags(bx, by, 640, 16, 96, 480, 10, 2);
      sf = exp_flags(sx, sy, 8, 2, 2, 4, 1, 1);
      bh = bf[3]; bv = bf[2]; sh = sf[3]; sv = sf[2];
      bhd = old_bh; bvd = old_bv; shd = old_sh; svd = old_sv;
    end
    #1;
    chk("big_x", b_x, bx);
    chk("big_y", b_y, by);
    chk("big_blank", b_blank, b_in_rst ? 1'b0 : bf[4]);
    chk("big_fs", b_fs, b_in_rst ? 1'b0 : bf[1]);
    chk("big_ls", b_ls, b_in_rst ? 1'b0 : bf[0]);
    chk("big_sync", b_sync, 1'b0);
    chk("small_x", s_x, sx);
    chk("small_y", s_y, sy);
    chk("small_blank", s_blank, s_in_rst ? 1'b0 : sf[4]);
    chk("small_fs", s_fs, s_in_rst ? 1'b0 : sf[1]);
    chk("small_ls", s_ls, s_in_rst ? 1'b0 : sf[0]);
`ifdef VGA_TIMING_SYNC_DELAY_EN
    chk("big_hs", b_hs, bhd);
    chk("big_vs", b_vs, bvd);
    chk("small_hs", s_hs, shd);
    chk("small_vs", s_vs, svd);
`else
    chk("big_hs", b_hs, bh);
    chk("big_vs", b_vs, bv);
    chk("small_hs", s_hs, sh);
    chk("small_vs", s_vs, sv);
`endif
  endtask

  initial begin
    int hs_low, ls_cnt, blank_fall_x, guard;
    int cyc, fs_seen, prev_fs, win_vs_low, win_hs_low, win_blank;

    // Reset held three cycles: every output sits at its reset value.
    rst = 1'b1;
    repeat (3) begin
      tick();
      chk("rst_x", b_x, 10'd0);
      chk("rst_y", b_y, 10'd0);
      chk("rst_blank", b_blank, 1'b0);
      chk("rst_hs", b_hs, 1'b1);
      chk("rst_vs", b_vs, 1'b1);
      chk("rst_fs", b_fs, 1'b0);
      chk("rst_ls", b_ls, 1'b0);
    end

    // Release: DrawX counts 1,2,3 on line 0 with blank high.
    rst = 1'b0;
    tick();
    chk("rel_x1", b_x, 10'd1);
    chk("rel_y", b_y, 10'd0);
    chk("rel_blank", b_blank, 1'b1);
    chk("rel_hs", b_hs, 1'b1);
    chk("rel_vs", b_vs, 1'b1);
    chk("rel_fs", b_fs, 1'b0);
    tick();
    chk("rel_x2", b_x, 10'd2);
    tick();
    chk("rel_x3", b_x, 10'd3);

    // Rest of line 0: blank falls at 640, hs low for 96 cycles, no line_start before wrap.
    hs_low = 0; ls_cnt = 0; blank_fall_x = -1; guard = 0;
    while (b_x != 10'd799 && guard < 1000) begin
      tick();
      guard++;
      if (b_hs == 1'b0) hs_low++;
      if (b_ls == 1'b1) ls_cnt++;
      if (b_blank == 1'b0 && blank_fall_x < 0) blank_fall_x = int'(b_x);
    end
    chk("line0_reached_end", guard < 1000, 1'b1);
    chk("line0_blank_fall_x", blank_fall_x, 640);
    chk("line0_hs_low_cycles", hs_low, 96);
    chk("line0_no_ls", ls_cnt, 0);

    // Wrap 799 -> 0 with DrawY +1 and a single-cycle line_start.
    tick();
    chk("wrap_x", b_x, 10'd0);
    chk("wrap_y", b_y, 10'd1);
    chk("wrap_ls", b_ls, 1'b1);
    chk("wrap_fs", b_fs, 1'b0);
    chk("wrap_blank", b_blank, 1'b1);
    tick();
    chk("after_wrap_ls", b_ls, 1'b0);
    chk("after_wrap_x", b_x, 10'd1);

    // Mid-frame reset inside the hsync window (DrawX=700 on line 2).
    guard = 0;
    while (!(b_x == 10'd700 && b_y == 10'd2) && guard < 3000) begin
      tick();
      guard++;
    end
    chk("mid_reached", (b_x == 10'd700) && (b_y == 10'd2), 1'b1);
    rst = 1'b1;
    tick();
    chk("mid_rst_x", b_x, 10'd0);
    chk("mid_rst_y", b_y, 10'd0);
    chk("mid_rst_hs", b_hs, 1'b1);
    chk("mid_rst_vs", b_vs, 1'b1);
    chk("mid_rst_blank", b_blank, 1'b0);
    rst = 1'b0;
    tick();
    chk("mid_resume_x", b_x, 10'd1);
    chk("mid_resume_y", b_y, 10'd0);

    // Small timing: 98-cycle frames, one 14-cycle vsync line, 2-cycle hsync per line, 32 visible pixels.
    cyc = 0; fs_seen = 0; prev_fs = -1;
    win_vs_low = 0; win_hs_low = 0; win_blank = 0;
    repeat (330) begin
      tick();
      cyc++;
      if (s_fs == 1'b1) begin
        if (prev_fs >= 0) chk("small_frame_period", cyc - prev_fs, 98);
        prev_fs = cyc;
        fs_seen++;
      end
      if (fs_seen == 1) begin
        if (s_vs == 1'b0) win_vs_low++;
        if (s_hs == 1'b0) win_hs_low++;
        if (s_blank == 1'b1) win_blank++;
      end
    end
    chk("small_frames_seen", fs_seen, 3);
    chk("small_vs_low_cycles", win_vs_low, 14);
    chk("small_hs_low_cycles", win_hs_low, 14);
    chk("small_visible_cycles", win_blank, 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
